// File: rtl/ahb_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// ahb_pkg : AHB transfer/burst/response encodings, arbiter states
// Rev 1.0
// ----------------------------------------------------------------
package ahb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    SINGLE = 3'd0,
    INCR   = 3'd1,
    WRAP4  = 3'd2,
    INCR4  = 3'd3,
    WRAP8  = 3'd4,
    INCR8  = 3'd5,
    WRAP16 = 3'd6,
    INCR16 = 3'd7
  } hburst_e;

  typedef enum logic [1:0] {
    OKAY  = 2'b00,
    ERROR = 2'b01,
    RETRY = 2'b10,
    SPLIT = 2'b11
  } hresp_e;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    BURST  = 2'd1,
    LOCKED = 2'd2
  } arb_state_e;

  // Undefined-length INCR counts as a single beat so it can be re-arbitrated every beat.
  function automatic logic [4:0] burst_len(hburst_e b);
    case (b)
      WRAP4, INCR4:   burst_len = 5'd4;
      WRAP8, INCR8:   burst_len = 5'd8;
      WRAP16, INCR16: burst_len = 5'd16;
      default:        burst_len = 5'd1;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_rr_picker.sv
`default_nettype none
// ----------------------------------------------------------------
// ahb_rr_picker : combinational round-robin, search starts one past ptr
// Rev 1.0
// ----------------------------------------------------------------
module ahb_rr_picker #(
  parameter int N = 4,
  localparam int MW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [MW-1:0] ptr,
  output logic [MW-1:0] winner,
  output logic          any_req
);

  logic [MW:0] idx;

  // Walk from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    winner  = '0;
    idx     = '0;
    any_req = |req;
    for (int i = N; i >= 1; i--) begin
      idx = {1'b0, ptr} + (MW+1)'(i);
      if (idx >= (MW+1)'(N)) idx = idx - (MW+1)'(N);
      if (req[idx[MW-1:0]]) winner = idx[MW-1:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ahb_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------
// ahb_bus_arbiter : round-robin AHB arbiter holding bursts and locks
// Rev 1.0
// ----------------------------------------------------------------
module ahb_bus_arbiter
  import ahb_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic [NUM_MASTERS-1:0] HBUSREQ,
  input  logic [NUM_MASTERS-1:0] HLOCK,
  input  logic [1:0]             HTRANS,
  input  logic [2:0]             HBURST,
  input  logic                   HREADY,
  input  logic [1:0]             HRESP,
  output logic [NUM_MASTERS-1:0] HGRANT,
  output logic [MW-1:0]          HMASTER,
  output logic [MW-1:0]          HMASTER_D,
  output logic                   HMASTLOCK
);

  arb_state_e             state, state_nxt;
  logic [3:0]             rem, rem_nxt;
  logic [MW-1:0]          rr_ptr, pick, win_idx;
  logic [NUM_MASTERS-1:0] grant_nxt;
  logic [4:0]             len;
  logic                   any_req, owner_lock, err, burst_start, arb_ok;

  ahb_rr_picker #(.N(NUM_MASTERS)) u_picker (
    .req    (HBUSREQ),
    .ptr    (rr_ptr),
    .winner (pick),
    .any_req(any_req)
  );

  // Lock is taken from the granted master so a lock requester keeps its grant
  // into its first address phase; rr_ptr always equals the grant index.
  always_comb begin
    owner_lock  = HLOCK[rr_ptr];
    err         = (hresp_e'(HRESP) != OKAY);
    len         = burst_len(hburst_e'(HBURST));
    burst_start = (htrans_e'(HTRANS) == NONSEQ) && (len > 5'd1);

    rem_nxt = rem;
    case (htrans_e'(HTRANS))
      NONSEQ:  rem_nxt = 4'(len - 5'd1);
      SEQ:     if (rem != 4'd0) rem_nxt = rem - 4'd1;
      default: ;
    endcase
    if (err) rem_nxt = 4'd0;

    if (err)                    state_nxt = ARB;
    else if (owner_lock)        state_nxt = LOCKED;
    else if (rem_nxt != 4'd0)   state_nxt = BURST;
    else                        state_nxt = ARB;

    // rem_nxt <= 1 hands the grant over during the last beat's address phase.
    arb_ok = err || (!owner_lock &&
             (((state == ARB) && !burst_start) || (rem_nxt <= 4'd1)));

    win_idx            = any_req ? pick : MW'(DEFAULT_MASTER);
    grant_nxt          = '0;
    grant_nxt[win_idx] = 1'b1;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state     <= ARB;
      rem       <= 4'd0;
      rr_ptr    <= MW'(DEFAULT_MASTER);
      HGRANT    <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      HMASTER   <= MW'(DEFAULT_MASTER);
      HMASTER_D <= MW'(DEFAULT_MASTER);
      HMASTLOCK <= 1'b0;
    end else if (HREADY) begin
      state     <= state_nxt;
      rem       <= rem_nxt;
      if (arb_ok) begin
        HGRANT <= grant_nxt;
        rr_ptr <= win_idx;
      end
      HMASTER   <= rr_ptr;
      HMASTER_D <= HMASTER;
      HMASTLOCK <= owner_lock;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ahb_bus_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------
// tb_ahb_bus_arbiter : directed vectors, queued expectations, monitor
// Rev 1.0
// ----------------------------------------------------------------
module tb_ahb_bus_arbiter;
  import ahb_pkg::*;

  logic       HCLK    = 1'b0;
  logic       HRESETn = 1'b0;
  logic [3:0] HBUSREQ = '0;
  logic [3:0] HLOCK   = '0;
  logic [1:0] HTRANS  = 2'b00;
  logic [2:0] HBURST  = 3'b000;
  logic       HREADY  = 1'b1;
  logic [1:0] HRESP   = 2'b00;
  logic [3:0] HGRANT;
  logic [1:0] HMASTER, HMASTER_D;
  logic       HMASTLOCK;

  typedef struct {
    logic [3:0] g;
    logic [1:0] m;
    logic [1:0] md;
    logic       ml;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  exp_t r;
  int   checks = 0;
  int   errors = 0;
  event chk_now;

  ahb_bus_arbiter #(.NUM_MASTERS(4), .DEFAULT_MASTER(0)) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .HBUSREQ  (HBUSREQ),
    .HLOCK    (HLOCK),
    .HTRANS   (HTRANS),
    .HBURST   (HBURST),
    .HREADY   (HREADY),
    .HRESP    (HRESP),
    .HGRANT   (HGRANT),
    .HMASTER  (HMASTER),
    .HMASTER_D(HMASTER_D),
    .HMASTLOCK(HMASTLOCK)
  );

  always #5 HCLK = ~HCLK;

  // Drive one cycle of bus inputs and queue the outputs expected after the next edge.
  task automatic step(input logic [3:0] req, lk, input logic [1:0] tr, input logic [2:0] bu,
                      input logic rdy, input logic [1:0] rs,
                      input logic [3:0] g, input logic [1:0] m, md, input logic ml,
                      input string nm);
    exp_t x;
    @(negedge HCLK);
    HRESETn = 1'b1;
    HBUSREQ = req;
    HLOCK   = lk;
    HTRANS  = tr;
    HBURST  = bu;
    HREADY  = rdy;
    HRESP   = rs;
    x.g = g; x.m = m; x.md = md; x.ml = ml; x.name = nm;
    exp_q.push_back(x);
  endtask

  always begin
    @(posedge HCLK or chk_now);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({HGRANT, HMASTER, HMASTER_D, HMASTLOCK} !== {e.g, e.m, e.md, e.ml}) begin
        errors++;
        $display("FAIL %s: got grant=%b master=%0d master_d=%0d lock=%b, want grant=%b master=%0d master_d=%0d lock=%b",
                 e.name, HGRANT, HMASTER, HMASTER_D, HMASTLOCK, e.g, e.m, e.md, e.ml);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge HCLK);

    // reset state, frozen and then idle
    step(4'b0000, 4'b0000, IDLE,   SINGLE, 1'b0, OKAY,  4'b0001, 2'd0, 2'd0, 1'b0, "rst_hold");
    step(4'b0000, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd0, 2'd0, 1'b0, "rst_idle");

    // all request, SINGLE transfers: grant rotates, HMASTER / HMASTER_D lag
    step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b0010, 2'd0, 2'd0, 1'b0, "rot1");
    step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b0100, 2'd1, 2'd0, 1'b0, "rot2");
    step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b1000, 2'd2, 2'd1, 1'b0, "rot3");
    step(4'b1111, 4'b0000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b0001, 2'd3, 2'd2, 1'b0, "rot4");

    // M1 INCR4 with M2 waiting: handover on beat 3, M2 owns after beat 4
    step(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0010, 2'd0, 2'd3, 1'b0, "c_gnt");
    step(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0010, 2'd1, 2'd0, 1'b0, "c_own");
    step(4'b0110, 4'b0000, NONSEQ, INCR4,  1'b1, OKAY,  4'b0010, 2'd1, 2'd1, 1'b0, "c_beat1");
    step(4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, OKAY,  4'b0010, 2'd1, 2'd1, 1'b0, "c_beat2");
    step(4'b0110, 4'b0000, SEQ,    INCR4,  1'b1, OKAY,  4'b0100, 2'd1, 2'd1, 1'b0, "c_beat3");
    step(4'b0100, 4'b0000, SEQ,    INCR4,  1'b1, OKAY,  4'b0100, 2'd2, 2'd1, 1'b0, "c_beat4");

    // M2 INCR8 with three wait cycles after beat 3, M3 waiting
    step(4'b1100, 4'b0000, NONSEQ, INCR8,  1'b1, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_beat1");
    step(4'b1100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_beat2");
    step(4'b1100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_beat3");
    for (int k = 0; k < 3; k++)
      step(4'b1100, 4'b0000, SEQ,  INCR8,  1'b0, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_stall");
    step(4'b1100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_beat4");
    step(4'b1100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_beat5");
    step(4'b1100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0100, 2'd2, 2'd2, 1'b0, "d_beat6");
    step(4'b1100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b1000, 2'd2, 2'd2, 1'b0, "d_beat7");
    step(4'b1000, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b1000, 2'd3, 2'd2, 1'b0, "d_beat8");

    // M3 locked over three SINGLEs while M0 requests, then release
    step(4'b1001, 4'b1000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b1000, 2'd3, 2'd3, 1'b1, "e_lock1");
    step(4'b1001, 4'b1000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b1000, 2'd3, 2'd3, 1'b1, "e_lock2");
    step(4'b1001, 4'b1000, NONSEQ, SINGLE, 1'b1, OKAY,  4'b1000, 2'd3, 2'd3, 1'b1, "e_lock3");
    step(4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd3, 2'd3, 1'b0, "e_release");

    // M0 WRAP16 terminated by ERROR on beat 2, M1 pending
    step(4'b0001, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0001, 2'd0, 2'd3, 1'b0, "f_gnt");
    step(4'b0011, 4'b0000, NONSEQ, WRAP16, 1'b1, OKAY,  4'b0001, 2'd0, 2'd0, 1'b0, "f_beat1");
    step(4'b0011, 4'b0000, SEQ,    WRAP16, 1'b1, ERROR, 4'b0010, 2'd0, 2'd0, 1'b0, "f_error");
    step(4'b0010, 4'b0000, IDLE,   SINGLE, 1'b1, OKAY,  4'b0010, 2'd1, 2'd0, 1'b0, "f_after");

    // M1 INCR8 interrupted by asynchronous reset between edges
    step(4'b0010, 4'b0000, NONSEQ, INCR8,  1'b1, OKAY,  4'b0010, 2'd1, 2'd1, 1'b0, "g_beat1");
    step(4'b0010, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0010, 2'd1, 2'd1, 1'b0, "g_beat2");
    @(negedge HCLK);
    HRESETn = 1'b0;
    r.g = 4'b0001; r.m = 2'd0; r.md = 2'd0; r.ml = 1'b0; r.name = "async_rst";
    exp_q.push_back(r);
    -> chk_now;
    // beat counter must have been cleared: a SEQ here re-arbitrates at once
    step(4'b0100, 4'b0000, SEQ,    INCR8,  1'b1, OKAY,  4'b0100, 2'd0, 2'd0, 1'b0, "g_post");

    repeat (2) @(posedge HCLK);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ahb_bus_arbiter.md
# ahb_bus_arbiter

Round-robin AHB bus arbiter that shares one AHB address/data bus among `NUM_MASTERS` masters. It sits beside the master-side multiplexers in the AHB interconnect. It generates the one-hot `HGRANT`, the address-phase owner `HMASTER`, the data-phase owner `HMASTER_D` that steers the `HWDATA` mux, and `HMASTLOCK`. Ownership never changes inside a fixed-length burst or a locked sequence, and only transfers on an `HREADY`-high clock edge.

## Interface
- `NUM_MASTERS`, 4: number of requesting masters (2–16).
- `DEFAULT_MASTER`, 0: master granted when nobody requests.
- `MW`, `$clog2(NUM_MASTERS)`: width of the master index (local parameter).

- `HCLK`  in  1  bus clock. There is one clock; all state changes on the rising edge.
- `HRESETn`  in  1  reset, asynchronous, active-low.
- `HBUSREQ`  in  NUM_MASTERS  bus request, one bit per master.
- `HLOCK`  in  NUM_MASTERS  locked-transfer request, one bit per master.
- `HTRANS`  in  2  transfer type of the current address-phase owner.
- `HBURST`  in  3  burst type of the current owner.
- `HREADY`  in  1  bus-wide ready.
- `HRESP`  in  2  slave response.
- `HGRANT`  out  NUM_MASTERS  one-hot grant.
- `HMASTER`  out  MW  address-phase owner.
- `HMASTER_D`  out  MW  data-phase owner.
- `HMASTLOCK`  out  1  the current address phase is locked.

## Operation
- **Reset values:** `HGRANT` is one-hot at `DEFAULT_MASTER`; `HMASTER` = `HMASTER_D` = `DEFAULT_MASTER`; `HMASTLOCK` = 0; beat counter = 0; RR pointer = `DEFAULT_MASTER`.
- **States:**
  - ARB: free to re-arbitrate.
  - BURST: fixed-length burst in progress.
  - LOCKED: the owner's `HLOCK` is high.
- **Accepted address phase:** a rising edge with `HREADY`=1. All registers below update only on such edges, except the asynchronous reset.
- **Burst length** comes from `HBURST`:
  - SINGLE = 1.
  - INCR = unbounded, treated as 1; arbitration is allowed on every beat.
  - WRAP4 / INCR4 = 4.
  - WRAP8 / INCR8 = 8.
  - WRAP16 / INCR16 = 16.
- **Beat counter `rem`** (remaining beats after the accepted one, 4 bits):
  - NONSEQ accepted with a fixed burst: `rem` <= len−1, state goes to BURST.
  - SEQ accepted: `rem` <= `rem`−1.
  - BUSY or IDLE: `rem` is held.
- **`arb_ok`** is true at an accepted edge when either condition holds:
  - state is ARB and the owner's `HLOCK` is 0;
  - the next value of `rem` is ≤ 1 and `HLOCK` is 0. The grant then moves during the last beat's address phase, so the new master takes ownership at the edge that ends it.
- **Early burst termination:** when `HRESP` ≠ OKAY (ERROR, RETRY or SPLIT), `rem` <= 0, state goes to ARB, and `arb_ok` is forced true (unless LOCKED with `HRESP` = OKAY).
- **Winner selection:** when `arb_ok`, the winner is the first requesting master in round-robin order, starting one past the RR pointer. If there are no requests, the winner is `DEFAULT_MASTER`. `HGRANT` <= onehot(winner) and RR pointer <= winner.
- **Ownership registers** at every accepted edge:
  - `HMASTER` <= index(`HGRANT`);
  - `HMASTER_D` <= `HMASTER`;
  - `HMASTLOCK` <= `HLOCK`[index(`HGRANT`)].
- **Lock:** while `HLOCK`[`HMASTER`] = 1 the state is LOCKED and `HGRANT` is frozen. Release takes effect at the first accepted edge where it is 0.

## Timing
- Request to grant: 1 edge, when `arb_ok`.
- Grant to `HMASTER`: 1 further accepted edge.
- `HMASTER` to `HMASTER_D`: 1 further accepted edge.
- `HREADY`=0 freezes all state and outputs.
- Simultaneous requests are resolved by the RR pointer; there is no fixed priority.
- A request that drops while already granted has no effect until the next `arb_ok`.
- Reset asserted mid-burst returns all outputs to reset values immediately, without waiting for the clock.

## Structure
- Package `ahb_pkg`:
  - `htrans_e` (IDLE, BUSY, NONSEQ, SEQ);
  - `hburst_e`;
  - `hresp_e` (OKAY, ERROR, RETRY, SPLIT);
  - function `burst_len(hburst_e)`.
- Sub-module `ahb_rr_picker`: combinational round-robin, taking requests and pointer and returning winner and any-request.
- RTL target: about 200 lines.

## Test plan
- **Reset, no requests:** `HGRANT`=0001, `HMASTER`=0, `HMASTER_D`=0, `HMASTLOCK`=0.
- **All four masters request continuously with SINGLE transfers:** grant rotates 1→2→3→0 on consecutive accepted edges; `HMASTER` lags `HGRANT` by 1 edge and `HMASTER_D` lags by 2.
- **M1 issues INCR4 while M2 requests:** `HGRANT` moves to M2 at the edge accepting beat 3. `HMASTER`=2 exactly after beat 4 is accepted, with no gap and no overlap.
- **`HREADY` low for 3 cycles mid-INCR8:** all outputs hold; the counter resumes and the switch happens after beat 8.
- **M3 holds `HLOCK` over 3 SINGLEs while M0 requests:** grant is stuck at M3 and `HMASTLOCK`=1; after `HLOCK` drops, M0 is granted at the next accepted edge.
- **ERROR response on beat 2 of WRAP16:** re-arbitration happens at that edge; a pending requester gets `HGRANT` immediately.
